// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable timer with a prescaler, a period compare and run control.
// It supports one-shot and periodic (auto-reload) modes. It emits a single-cycle
// terminal-count tick, and a done pulse when a one-shot run completes.
// period, prescale and mode are captured on start. The live inputs may change freely
// while the timer runs.
module timer_ctrl #(
  parameter int N = 4,
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         mode,
  input  logic [N-1:0] period,
  input  logic [P-1:0] prescale,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         tick,
  output logic         done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N-1:0] Q_ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] PRE_ONE = {{(P-1){1'b0}}, 1'b1};

  state_t       state;
  logic [P-1:0] pre_cnt;
  logic [N-1:0] period_r;
  logic [P-1:0] prescale_r;
  logic         mode_r;

  // Run-control FSM: the counter datapath and all outputs are registered here.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      q          <= '0;
      pre_cnt    <= '0;
      period_r   <= '0;
      prescale_r <= '0;
      mode_r     <= 1'b0;
      busy       <= 1'b0;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            period_r   <= period;
            prescale_r <= prescale;
            mode_r     <= mode;
            q          <= '0;
            pre_cnt    <= '0;
            state      <= RUN;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            // Abort has the highest priority: it overrides restart, pause and terminal count.
            q       <= '0;
            pre_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (start) begin
            // Restart from zero with a fresh configuration. This does not produce a tick.
            period_r   <= period;
            prescale_r <= prescale;
            mode_r     <= mode;
            q          <= '0;
            pre_cnt    <= '0;
          end else if (pause) begin
            // Freeze q and pre_cnt. tick is already defaulted low.
          end else if (pre_cnt != prescale_r) begin
            pre_cnt <= pre_cnt + PRE_ONE;
          end else begin
            pre_cnt <= '0;
            if (q != period_r) begin
              q <= q + Q_ONE;
            end else begin
              // Terminal count: wrap to zero and pulse tick. A one-shot run also finishes here.
              q    <= '0;
              tick <= 1'b1;
              if (!mode_r) begin
                done  <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Testbench for timer_ctrl. Directed scenarios are followed by a randomized run.
// Each output is compared against a cycle-count model of the timer. The model tracks
// the number of un-paused run cycles elapsed since start, and derives q, tick and done
// arithmetically from that count.
module tb_timer_ctrl;
  localparam int N = 4;
  localparam int P = 8;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] period = '0;
  logic [P-1:0] prescale = '0;
  logic [N-1:0] q;
  logic         busy;
  logic         tick;
  logic         done;

  timer_ctrl #(.N(N), .P(P)) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .period(period), .prescale(prescale),
    .q(q), .busy(busy), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit m_run  = 0;
  int m_el   = 0;
  int m_per  = 0;
  int m_ps   = 0;
  bit m_mode = 0;
  bit m_tick = 0;
  bit m_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_q();
    return m_run ? (m_el / (m_ps + 1)) : 0;
  endfunction

  task automatic m_capture();
    m_per  = int'(period);
    m_ps   = int'(prescale);
    m_mode = mode;
    m_el   = 0;
  endtask

  task automatic m_reset();
    m_run = 0; m_el = 0; m_per = 0; m_ps = 0; m_mode = 0; m_tick = 0; m_done = 0;
  endtask

  // Advance the model by one clock edge, using the inputs that are currently applied.
  task automatic model_edge();
    m_tick = 0;
    m_done = 0;
    if (!m_run) begin
      if (start && !stop) begin
        m_capture();
        m_run = 1;
      end
    end else if (stop) begin
      m_run = 0;
      m_el  = 0;
    end else if (start) begin
      m_capture();
    end else if (!pause) begin
      m_el++;
      if (m_el == (m_per + 1) * (m_ps + 1)) begin
        m_el   = 0;
        m_tick = 1;
        if (!m_mode) begin
          m_done = 1;
          m_run  = 0;
        end
      end
    end
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, "_q"},    32'(q),    32'(m_q()));
    check({pfx, "_busy"}, 32'(busy), 32'(m_run));
    check({pfx, "_tick"}, 32'(tick), 32'(m_tick));
    check({pfx, "_done"}, 32'(done), 32'(m_done));
  endtask

  task automatic step(input string pfx);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(pfx);
  endtask

  task automatic steps(input string pfx, input int n);
    for (int i = 0; i < n; i++) step(pfx);
  endtask

  task automatic drive(input bit st, input bit sp, input bit pa, input bit md,
                       input int per, input int ps);
    start    = st;
    stop     = sp;
    pause    = pa;
    mode     = md;
    period   = N'(per);
    prescale = P'(ps);
  endtask

  // Assert reset between clock edges, hold it across one edge, then release it.
  task automatic reset_mid(input string pfx);
    #2;
    aresetn = 1'b0;
    #1;
    m_reset();
    compare_all({pfx, "_async"});
    @(posedge clk);
    #1;
    compare_all({pfx, "_held"});
    #3;
    aresetn = 1'b1;
  endtask

  initial begin
    // Check the reset state before the first clock edge.
    #1;
    compare_all("por");
    #2;
    aresetn = 1'b1;

    // Reset mid-run: periodic, period=9, prescale=0. Reset is asserted at q=5.
    drive(1, 0, 0, 1, 9, 0);
    step("rst_start");
    drive(0, 0, 0, 1, 9, 0);
    steps("rst_run", 5);
    check("rst_q_is_5", 32'(q), 32'd5);
    reset_mid("rst");
    steps("rst_idle", 4);

    // Periodic, period=3, prescale=0: tick every 4 cycles, done never asserts.
    drive(1, 0, 0, 1, 3, 0);
    step("per_start");
    drive(0, 0, 0, 0, 0, 0);
    steps("per_run", 13);

    // One-shot, period=2, prescale=1: tick and done after 6 cycles, then idle.
    drive(1, 0, 0, 0, 2, 1);
    step("os_start");
    drive(0, 0, 0, 1, 7, 5);
    steps("os_run", 6);
    check("os_done_pulse", 32'(done), 32'd1);
    check("os_busy_low", 32'(busy), 32'd0);
    steps("os_idle", 5);

    // Stop and start together at q=2: stop wins. Then restart with period=1.
    drive(1, 0, 0, 1, 3, 0);
    step("ss_start");
    drive(0, 0, 0, 1, 3, 0);
    steps("ss_run", 2);
    drive(1, 1, 0, 1, 3, 0);
    step("ss_both");
    drive(1, 0, 0, 1, 1, 0);
    step("ss_restart");
    drive(0, 0, 0, 1, 1, 0);
    steps("ss_run2", 3);
    drive(1, 0, 0, 1, 1, 0);
    step("ss_rerun");
    drive(0, 0, 0, 1, 1, 0);
    steps("ss_run3", 4);

    // Pause for 5 cycles at q=1, pre_cnt=1, with period=3, prescale=2.
    drive(1, 0, 0, 1, 3, 2);
    step("pz_start");
    drive(0, 0, 0, 1, 3, 2);
    steps("pz_run", 4);
    drive(0, 0, 1, 1, 3, 2);
    steps("pz_hold", 5);
    drive(0, 0, 0, 1, 3, 2);
    steps("pz_resume", 14);

    // period=0, prescale=3: q stays 0 and tick fires every 4 cycles.
    drive(1, 0, 0, 1, 0, 3);
    step("p0_start");
    drive(0, 0, 0, 1, 0, 3);
    steps("p0_run", 12);

    // Full-range count, period=15, prescale=0. period changes to 5 mid-run without effect.
    drive(1, 0, 0, 1, 15, 0);
    step("full_start");
    drive(0, 0, 0, 1, 15, 0);
    steps("full_run", 8);
    drive(0, 0, 0, 0, 5, 2);
    steps("full_chg", 30);
    drive(0, 1, 0, 0, 5, 2);
    step("full_stop");

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 49) == 0,
            $urandom_range(0, 4) == 0, 1'($urandom),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      step("rnd");
      if ($urandom_range(0, 399) == 0) reset_mid("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
